// File: rtl/apb_ram_slave.sv
// apb_ram_slave: APB slave in front of a word-addressed RAM.
// The slave inserts a configurable number of wait states before PREADY.
// PRDATA, PREADY and PSLVERR are all registered outputs.
// Optional feature: define APB_RAM_PSLVERR_EN to flag transfers with PADDR >= DEPTH.
// Such a transfer completes with PSLVERR=1, its write is dropped and it reads 0.
// Without the macro, PSLVERR is tied low and addresses alias modulo DEPTH.
module apb_ram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET_N,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e                state_q,   state_d;
  logic [3:0]            cnt_q,     cnt_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic                  write_q,   write_d;
  logic                  err_q,     err_d;
  logic [DATA_WIDTH-1:0] prdata_q,  prdata_d;
  logic                  pready_q,  pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Word index and out-of-range flag of the address currently on the bus.
  logic [31:0]      paddr_ext;
  logic [IDX_W-1:0] paddr_idx;
  logic             paddr_oor;

  assign paddr_ext = 32'(PADDR);
  assign paddr_idx = IDX_W'(paddr_ext % 32'(DEPTH));
`ifdef APB_RAM_PSLVERR_EN
  assign paddr_oor = (paddr_ext >= 32'(DEPTH));
`else
  assign paddr_oor = 1'b0;
`endif

  // State register plus the transfer context captured at setup.
  // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  // Next-state logic: setup detect, wait countdown, completion and PSEL-drop abort.
  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // PSEL with PENABLE already high is not a setup phase and is ignored.
        if (PSEL && !PENABLE) begin
          idx_d   = paddr_idx;
          write_d = PWRITE;
          err_d   = paddr_oor;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_READY;
          end
        end
      end
      ST_READY: begin
        // Either a normal completion or a master abort ends up idle.
        if (!PSEL || PENABLE) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: registered handshake flags, read-data load and RAM write strobe.
  always_comb begin
    pready_d  = (state_d == ST_READY);
    pslverr_d = (state_d == ST_READY) && err_d;
    prdata_d  = prdata_q;
    // Read data is fetched once, on the edge that enters READY.
    if ((state_d == ST_READY) && (state_q != ST_READY) && !write_d) begin
      prdata_d = err_d ? '0 : mem[idx_d];
    end
    // PWDATA is taken at the completion edge, not at setup.
    mem_we = (state_q == ST_READY) && PSEL && PENABLE && write_q && !err_q;
  end

  // RAM array write port.
  // NOTE: the array has no reset; its contents survive PRESET_N.
  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      mem[idx_q] <= PWDATA;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_ram_slave.sv
// tb_apb_ram_slave: scoreboard bench for apb_ram_slave.
// Two instances share one reset: index 0 has WAIT_STATES=0, index 1 has WAIT_STATES=3.
// The driver queues the expected response for each transfer.
// The monitor counts access cycles with PREADY low and compares at the completion cycle.
module tb_apb_ram_slave;

  typedef struct {
    int          dut;
    logic        rd;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       psel, penable, pwrite;
  logic [1:0][7:0]  paddr;
  logic [1:0][31:0] pwdata;
  logic [31:0]      prdata_0, prdata_1;
  logic             pready_0, pready_1, pslverr_0, pslverr_1;
  logic [1:0]       pready, pslverr;

  assign pready  = {pready_1, pready_0};
  assign pslverr = {pslverr_1, pslverr_0};

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   waits[2];

  apb_ram_slave #(.WAIT_STATES(0)) u_dut0 (
    .PCLK(clk), .PRESET_N(rst_n), .PADDR(paddr[0]), .PSEL(psel[0]),
    .PENABLE(penable[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
    .PRDATA(prdata_0), .PREADY(pready_0), .PSLVERR(pslverr_0)
  );

  apb_ram_slave #(.WAIT_STATES(3)) u_dut3 (
    .PCLK(clk), .PRESET_N(rst_n), .PADDR(paddr[1]), .PSEL(psel[1]),
    .PENABLE(penable[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
    .PRDATA(prdata_1), .PREADY(pready_1), .PSLVERR(pslverr_1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One full transfer starting at posedge+1 and ending at posedge+1 after completion.
  // With scramble set, PADDR and PWDATA are disturbed while the slave is waiting.
  task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_waits, input logic scramble);
    exp_t e;
    bit   done;
    e.dut = d; e.rd = !wr; e.data = exp_data; e.err = exp_err; e.waits = exp_waits;
    sb_q.push_back(e);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = scramble ? ~wdata : wdata;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    if (scramble) paddr[d] = ~addr;
    done = 1'b0;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      if (pready[d]) done = 1'b1;
    end
    check($sformatf("dut%0d_pready_within_budget", d), 32'(done), 32'd1);
    if (!done) e = sb_q.pop_back();
    if (scramble) pwdata[d] = wdata;
    @(posedge clk); #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // Monitor: checks latency, PSLVERR and read data at each completion cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      waits[0] = 0;
      waits[1] = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (psel[d] && penable[d]) begin
          if (!pready[d]) begin
            waits[d]++;
          end else begin
            if (sb_q.size() == 0) begin
              n_checks++;
              $display("FAIL dut%0d_unexpected_completion: got completion expected none (t=%0t)", d, $time);
            end else begin
              e = sb_q.pop_front();
              check("sb_dut", 32'(d), 32'(e.dut));
              check($sformatf("dut%0d_waits", d), 32'(waits[d]), 32'(e.waits));
              check($sformatf("dut%0d_pslverr", d), 32'(pslverr[d]), 32'(e.err));
              if (e.rd) check($sformatf("dut%0d_prdata", d), (d == 0) ? prdata_0 : prdata_1, e.data);
            end
            waits[d] = 0;
          end
        end else begin
          waits[d] = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    psel    = '0;
    penable = '0;
    pwrite  = '0;
    paddr   = '0;
    pwdata  = '0;
    #12;
    check("rst_pready0",  32'(pready_0),  32'd0);
    check("rst_pslverr0", 32'(pslverr_0), 32'd0);
    check("rst_prdata0",  prdata_0,       32'd0);
    check("rst_pready1",  32'(pready_1),  32'd0);
    check("rst_pslverr1", 32'(pslverr_1), 32'd0);
    check("rst_prdata1",  prdata_1,       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero wait states: write then read back.
    apb_xfer(0, 1'b1, 8'h05, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b0);
    apb_xfer(0, 1'b0, 8'h05, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b0);

    // Back-to-back transfers with no idle cycle.
    apb_xfer(0, 1'b1, 8'h01, 32'h11111111, 32'h0,        1'b0, 0, 1'b0);
    apb_xfer(0, 1'b1, 8'h02, 32'h22222222, 32'h0,        1'b0, 0, 1'b0);
    apb_xfer(0, 1'b0, 8'h01, 32'h0,        32'h11111111, 1'b0, 0, 1'b0);
    apb_xfer(0, 1'b0, 8'h02, 32'h0,        32'h22222222, 1'b0, 0, 1'b0);

    // PSEL+PENABLE from IDLE without setup must not start a transfer.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
    paddr[0] = 8'h05; pwdata[0] = 32'h0BAD0BAD;
    repeat (3) @(negedge clk);
    check("idle_access_ignored_pready", 32'(pready_0), 32'd0);
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0;
    apb_xfer(0, 1'b0, 8'h05, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);

    // Out-of-range address 0x45 with DEPTH=64.
`ifdef APB_RAM_PSLVERR_EN
    apb_xfer(0, 1'b1, 8'h45, 32'hCAFEF00D, 32'h0,        1'b1, 0, 1'b0);
    apb_xfer(0, 1'b0, 8'h05, 32'h0,        32'hDEADBEEF, 1'b0, 0, 1'b0);
    apb_xfer(0, 1'b0, 8'h45, 32'h0,        32'h0,        1'b1, 0, 1'b0);
`else
    apb_xfer(0, 1'b1, 8'h45, 32'hCAFEF00D, 32'h0,        1'b0, 0, 1'b0);
    apb_xfer(0, 1'b0, 8'h05, 32'h0,        32'hCAFEF00D, 1'b0, 0, 1'b0);
`endif

    // Three wait states.
    apb_xfer(1, 1'b1, 8'h10, 32'h0BADF00D, 32'h0,        1'b0, 3, 1'b0);
    apb_xfer(1, 1'b0, 8'h10, 32'h0,        32'h0BADF00D, 1'b0, 3, 1'b0);

    // Address and data wiggle during WAIT: setup address and final PWDATA are used.
    apb_xfer(1, 1'b1, 8'h20, 32'h5A5A0FF0, 32'h0,        1'b0, 3, 1'b1);
    apb_xfer(1, 1'b0, 8'h20, 32'h0,        32'h5A5A0FF0, 1'b0, 3, 1'b0);

    // PSEL dropped during WAIT aborts the write.
    apb_xfer(1, 1'b1, 8'h07, 32'h01234567, 32'h0, 1'b0, 3, 1'b0);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h07; pwdata[1] = 32'h00000077;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(negedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_pready", 32'(pready_1), 32'd0);
    @(posedge clk); #1;
    apb_xfer(1, 1'b0, 8'h07, 32'h0, 32'h01234567, 1'b0, 3, 1'b0);

    // Reset asserted in WAIT during a write aborts it; RAM contents survive.
    apb_xfer(1, 1'b1, 8'h03, 32'h12345678, 32'h0,        1'b0, 3, 1'b0);
    apb_xfer(1, 1'b0, 8'h03, 32'h0,        32'h12345678, 1'b0, 3, 1'b0);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 8'h03; pwdata[1] = 32'hA5A5A5A5;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_pready1",  32'(pready_1),  32'd0);
    check("midrst_pslverr1", 32'(pslverr_1), 32'd0);
    check("midrst_prdata1",  prdata_1,       32'd0);
    check("midrst_prdata0",  prdata_0,       32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    // The setup phase is driven right after release and must be taken at the first edge.
    apb_xfer(1, 1'b0, 8'h03, 32'h0, 32'h12345678, 1'b0, 3, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_ram_slave.md
APB_RAM_SLAVE -- requirements
Module: apb_ram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, width of PADDR in bits; PADDR is a word address.
REQ-002 Parameter DATA_WIDTH, default 32, width of PWDATA and PRDATA.
REQ-003 Parameter DEPTH, default 64, number of words; SHALL be a power of two and not exceed 2**ADDR_WIDTH.
REQ-004 Parameter WAIT_STATES, default 1, range 0..15; extra access-phase cycles before PREADY asserts.
REQ-005 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-006 PCLK  input  1  clock; all state changes on the rising edge.
REQ-007 PRESET_N  input  1  asynchronous active-low reset.
REQ-008 PADDR  input  ADDR_WIDTH  transfer word address.
REQ-009 PSEL  input  1  slave select.
REQ-010 PENABLE  input  1  access-phase indicator.
REQ-011 PWRITE  input  1  1 = write, 0 = read.
REQ-012 PWDATA  input  DATA_WIDTH  write data.
REQ-013 PRDATA  output  DATA_WIDTH  registered read data.
REQ-014 PREADY  output  1  registered transfer-complete indicator.
REQ-015 PSLVERR  output  1  registered error flag, valid only while PREADY=1.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and READY.
REQ-017 Setup detect: at an edge with PSEL=1 and PENABLE=0, the FSM SHALL latch PADDR and PWRITE, load the wait counter with WAIT_STATES, and enter READY if WAIT_STATES=0, otherwise WAIT.
REQ-018 In WAIT, the counter SHALL decrement once per clock; on the edge where it decrements from 1 to 0, the FSM SHALL enter READY.
REQ-019 PREADY SHALL be 1 exactly while the FSM is in READY.
- Latency: the first access cycle has PREADY=1 when WAIT_STATES=0.
- Otherwise PREADY rises after WAIT_STATES access cycles.
REQ-020 Completion: at an edge with PSEL=1, PENABLE=1 and PREADY=1, the transfer SHALL complete.
- Write: mem[index] <= PWDATA on that edge.
- FSM returns to IDLE.
- A setup phase starting in the next cycle SHALL be accepted (back-to-back transfers, no idle cycle required).
REQ-021 Read: PRDATA SHALL be loaded with mem[index] on the edge entering READY and SHALL hold its value until the next read loads it; writes SHALL NOT change PRDATA.
REQ-022 Index SHALL be PADDR modulo DEPTH (low log2(DEPTH) bits), except as modified by REQ-029.
REQ-023 If PSEL drops while in WAIT or READY (protocol violation), the FSM SHALL return to IDLE at that edge with no memory write.
REQ-024 PADDR/PWDATA changes during WAIT SHALL be ignored for address; the write SHALL use PWDATA sampled at the completion edge.
REQ-025 PSEL=1 with PENABLE=1 while in IDLE SHALL be ignored (no transfer started).

Reset
REQ-026 When PRESET_N=0, the block SHALL immediately, without a clock, force state=IDLE, counter=0, PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer with no memory write; memory contents SHALL NOT be reset.
REQ-028 After PRESET_N rises, the first setup phase SHALL be accepted at the first rising edge.

Configuration
REQ-029 Macro APB_RAM_PSLVERR_EN SHALL select out-of-range handling.
- Defined: a PADDR >= DEPTH transfer SHALL complete with the normal wait states, with PSLVERR=1 while PREADY=1; the write SHALL be suppressed and PRDATA loaded with 0.
- Undefined: PSLVERR SHALL be constant 0 and out-of-range addresses SHALL alias per REQ-022.

Verification
REQ-030 WAIT_STATES=0: write 0xDEADBEEF to addr 0x05, then read 0x05 -> PREADY=1 in the first access cycle of each transfer, and PRDATA=0xDEADBEEF.
REQ-031 WAIT_STATES=3: read addr 0x10 -> PREADY=0 for 3 access cycles, =1 on the 4th; the bench SHALL check PRDATA only in the 4th.
REQ-032 Back-to-back: write 0x11111111 to addr 0x01 and 0x22222222 to addr 0x02 with no idle cycle, then read both -> 0x11111111 and 0x22222222.
REQ-033 Reset mid-transfer: assert PRESET_N=0 in WAIT during a write of 0xA5A5A5A5 to addr 0x03 that holds 0x12345678 -> PREADY/PSLVERR/PRDATA are 0 at once, and a read of 0x03 afterwards returns 0x12345678.
REQ-034 Out-of-range, DEPTH=64: write 0xCAFEF00D to addr 0x45.
- With APB_RAM_PSLVERR_EN: PSLVERR=1 with PREADY, and addr 0x05 is unchanged.
- Without it: PSLVERR=0, and a read of addr 0x05 returns 0xCAFEF00D.
